// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the APB GPIO controller: register offsets, the debounce
// divider width and the interrupt type encoding.
package gpio_ctrl_pkg;

   localparam logic [7:0] OFS_OE       = 8'h00;
   localparam logic [7:0] OFS_OUT      = 8'h04;
   localparam logic [7:0] OFS_IN       = 8'h08;
   localparam logic [7:0] OFS_OUT_SET  = 8'h0C;
   localparam logic [7:0] OFS_OUT_CLR  = 8'h10;
   localparam logic [7:0] OFS_OUT_TGL  = 8'h14;
   localparam logic [7:0] OFS_INT_EN   = 8'h18;
   localparam logic [7:0] OFS_INT_TYPE = 8'h1C;
   localparam logic [7:0] OFS_INT_POL  = 8'h20;
   localparam logic [7:0] OFS_INT_BOTH = 8'h24;
   localparam logic [7:0] OFS_INT_STAT = 8'h28;
   localparam logic [7:0] OFS_DB_EN    = 8'h2C;
   localparam logic [7:0] OFS_DB_DIV   = 8'h30;

   localparam int DB_DIV_W = 16;

   typedef enum logic {
      INT_LEVEL = 1'b0,
      INT_EDGE  = 1'b1
   } int_type_e;

endpackage

// File: rtl/gpio_ctrl_pin.sv
// One GPIO input lane: synchroniser, optional debounce (GPIO_DEBOUNCE_EN) and
// edge/level interrupt event generation.
module gpio_ctrl_pin
   import gpio_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic      apb_pclk,
   input  logic      apb_prstn,
   input  logic      pad,
   input  int_type_e int_type,
   input  logic      int_pol,
   input  logic      int_both,
`ifdef GPIO_DEBOUNCE_EN
   input  logic      db_en,
   input  logic      db_tick,
`endif
   output logic      in_val,
   output logic      evt
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   f;
   logic                   p;
   logic                   rise;
   logic                   fall;

   always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn) sync <= '0;
      else            sync <= {sync[SYNC_STAGES-2:0], pad};
   end

   assign s = sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   logic db_smp;
   logic db_val;

   // accept a new level only when two consecutive tick samples agree
   always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn) begin
         db_smp <= 1'b0;
         db_val <= 1'b0;
      end else if (db_tick) begin
         db_smp <= s;
         if (s == db_smp) db_val <= s;
      end
   end

   assign f = db_en ? db_val : s;
`else
   assign f = s;
`endif

   always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn) p <= 1'b0;
      else            p <= f;
   end

   assign rise   = f & ~p;
   assign fall   = ~f & p;
   assign in_val = f;

   always_comb begin
      evt = 1'b0;
      if (int_type == INT_EDGE) evt = int_both ? (rise | fall) : (int_pol ? rise : fall);
      else                      evt = (f == int_pol);
   end

endmodule

// File: rtl/gpio_ctrl.sv
// APB GPIO controller top: register file, APB decode and interrupt merge.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_ctrl
   import gpio_ctrl_pkg::*;
#(
   parameter int NUM_PINS    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                apb_pclk,
   input  logic                apb_prstn,
   input  logic                apb_psel,
   input  logic                apb_penable,
   input  logic                apb_pwrite,
   input  logic [31:0]         apb_paddr,
   input  logic [31:0]         apb_pwdata,
   output logic [31:0]         apb_prdata,
   output logic                apb_pslverr,
   input  logic [NUM_PINS-1:0] gpio_i,
   output logic [NUM_PINS-1:0] gpio_o,
   output logic [NUM_PINS-1:0] gpio_oe,
   output logic                irq
);

   logic [NUM_PINS-1:0] out_r, int_en, int_type, int_pol, int_both, int_stat;
   logic [NUM_PINS-1:0] in_vec, evt_vec, stat_n, en_n, wd;
   logic [31:0]         rdata;
   logic [7:0]          ofs;
   logic                acc, wr, hit;
   logic                unused_bits;

   assign acc         = apb_psel & apb_penable;
   assign wr          = acc & apb_pwrite;
   assign ofs         = apb_paddr[7:0];
   assign wd          = apb_pwdata[NUM_PINS-1:0];
   assign unused_bits = ^{apb_paddr[31:8], apb_pwdata};

`ifdef GPIO_DEBOUNCE_EN
   logic [NUM_PINS-1:0] db_en;
   logic [DB_DIV_W-1:0] db_div, db_cnt;
   logic                db_tick;

   // period is db_div + 1 cycles; db_div = 0 ticks every cycle
   assign db_tick = (db_cnt == '0);

   always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn)   db_cnt <= '0;
      else if (db_tick) db_cnt <= db_div;
      else              db_cnt <= db_cnt - 1'b1;
   end
`endif

   for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
      gpio_ctrl_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
         .apb_pclk  (apb_pclk),
         .apb_prstn (apb_prstn),
         .pad       (gpio_i[i]),
         .int_type  (int_type_e'(int_type[i])),
         .int_pol   (int_pol[i]),
         .int_both  (int_both[i]),
`ifdef GPIO_DEBOUNCE_EN
         .db_en     (db_en[i]),
         .db_tick   (db_tick),
`endif
         .in_val    (in_vec[i]),
         .evt       (evt_vec[i])
      );
   end

   always_comb begin
      hit   = 1'b1;
      rdata = '0;
      case (ofs)
         OFS_OE:       rdata[NUM_PINS-1:0] = gpio_oe;
         OFS_OUT:      rdata[NUM_PINS-1:0] = out_r;
         OFS_IN:       rdata[NUM_PINS-1:0] = in_vec;
         OFS_OUT_SET,
         OFS_OUT_CLR,
         OFS_OUT_TGL:  rdata = '0;
         OFS_INT_EN:   rdata[NUM_PINS-1:0] = int_en;
         OFS_INT_TYPE: rdata[NUM_PINS-1:0] = int_type;
         OFS_INT_POL:  rdata[NUM_PINS-1:0] = int_pol;
         OFS_INT_BOTH: rdata[NUM_PINS-1:0] = int_both;
         OFS_INT_STAT: rdata[NUM_PINS-1:0] = int_stat;
`ifdef GPIO_DEBOUNCE_EN
         OFS_DB_EN:    rdata[NUM_PINS-1:0] = db_en;
         OFS_DB_DIV:   rdata[DB_DIV_W-1:0] = db_div;
`endif
         default:      hit = 1'b0;
      endcase
   end

   assign apb_prdata  = (acc && !apb_pwrite && hit) ? rdata : '0;
   assign apb_pslverr = acc & ~hit;

   // a new event in the same cycle as a W1C wins, so active levels re-assert
   always_comb begin
      stat_n = int_stat;
      if (wr && ofs == OFS_INT_STAT) stat_n = stat_n & ~wd;
      stat_n = stat_n | (evt_vec & int_en);
      en_n   = (wr && ofs == OFS_INT_EN) ? wd : int_en;
   end

   always_ff @(posedge apb_pclk or negedge apb_prstn) begin
      if (!apb_prstn) begin
         gpio_oe  <= '0;
         out_r    <= '0;
         int_en   <= '0;
         int_type <= '0;
         int_pol  <= '0;
         int_both <= '0;
         int_stat <= '0;
         irq      <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
         db_en    <= '0;
         db_div   <= '0;
`endif
      end else begin
         int_stat <= stat_n;
         irq      <= |(stat_n & en_n);
         if (wr) begin
            case (ofs)
               OFS_OE:       gpio_oe  <= wd;
               OFS_OUT:      out_r    <= wd;
               OFS_OUT_SET:  out_r    <= out_r | wd;
               OFS_OUT_CLR:  out_r    <= out_r & ~wd;
               OFS_OUT_TGL:  out_r    <= out_r ^ wd;
               OFS_INT_EN:   int_en   <= wd;
               OFS_INT_TYPE: int_type <= wd;
               OFS_INT_POL:  int_pol  <= wd;
               OFS_INT_BOTH: int_both <= wd;
`ifdef GPIO_DEBOUNCE_EN
               OFS_DB_EN:    db_en    <= wd;
               OFS_DB_DIV:   db_div   <= apb_pwdata[DB_DIV_W-1:0];
`endif
               default:      ;
            endcase
         end
      end
   end

   assign gpio_o = out_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed and randomized bench for gpio_ctrl (12 pins, 2-stage sync, no debounce).
module tb_gpio_ctrl;

   localparam int N = 12;
   localparam logic [31:0] MASK = 32'h0000_0FFF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0]   paddr = '0, pwdata = '0;
   logic [31:0]   prdata;
   logic          pslverr;
   logic [N-1:0]  pad = '0;
   logic [N-1:0]  gpio_o, gpio_oe;
   logic          irq;

   int npass = 0;
   int ntotal = 0;

   always #5 clk = ~clk;

   gpio_ctrl #(.NUM_PINS(N), .SYNC_STAGES(2)) dut (
      .apb_pclk    (clk),
      .apb_prstn   (rst_n),
      .apb_psel    (psel),
      .apb_penable (penable),
      .apb_pwrite  (pwrite),
      .apb_paddr   (paddr),
      .apb_pwdata  (pwdata),
      .apb_prdata  (prdata),
      .apb_pslverr (pslverr),
      .gpio_i      (pad),
      .gpio_o      (gpio_o),
      .gpio_oe     (gpio_oe),
      .irq         (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      #1 err = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(posedge clk); #1;
      penable = 1'b1;
      #1 d = prdata; err = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp,
                         input logic exp_err);
      logic [31:0] d;
      logic        e;
      apb_rd(a, d, e);
      chk(tag, d, exp);
      chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic e;
      apb_wr(a, d, e);
   endtask

   // reference register state, kept as plain masked integers
   logic [31:0] m_oe, m_out, m_type, m_pol, m_both;

   function automatic logic [32:0] model_read(input logic [31:0] a);
      case (a)
         32'h00: return {1'b0, m_oe};
         32'h04: return {1'b0, m_out};
         32'h08: return {1'b0, 32'(pad)};
         32'h0C, 32'h10, 32'h14, 32'h18, 32'h28: return 33'h0;
         32'h1C: return {1'b0, m_type};
         32'h20: return {1'b0, m_pol};
         32'h24: return {1'b0, m_both};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d);
      case (a)
         32'h00: m_oe   = d & MASK;
         32'h04: m_out  = d & MASK;
         32'h0C: m_out  = (m_out | d) & MASK;
         32'h10: m_out  = m_out & ~d & MASK;
         32'h14: m_out  = (m_out ^ d) & MASK;
         32'h1C: m_type = d & MASK;
         32'h20: m_pol  = d & MASK;
         32'h24: m_both = d & MASK;
         default: ;
      endcase
   endtask

   initial begin
      logic [31:0] d, a;
      logic        e;
      logic [32:0] mr;
      logic [31:0] addrs [14];

      addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h3C};

      // reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_oe_pin", 32'(gpio_oe), 0);
      chk("rst_o_pin", 32'(gpio_o), 0);
      chk("rst_irq", {31'b0, irq}, 0);
      rd_chk("rst_oe", 32'h00, 0, 1'b0);
      rd_chk("rst_out", 32'h04, 0, 1'b0);
      rd_chk("rst_stat", 32'h28, 0, 1'b0);
      rd_chk("rst_dbdiv_undec", 32'h30, 0, 1'b1);

      // output operations
      wr(32'h04, 32'h0F0);
      wr(32'h0C, 32'h00F);
      rd_chk("out_set", 32'h04, 32'h0FF, 1'b0);
      wr(32'h10, 32'h0F0);
      rd_chk("out_clr", 32'h04, 32'h00F, 1'b0);
      wr(32'h14, 32'hFFF);
      rd_chk("out_tgl", 32'h04, 32'hFF0, 1'b0);
      chk("out_pin", 32'(gpio_o), 32'hFF0);
      rd_chk("tgl_reads0", 32'h14, 0, 1'b0);
      wr(32'hFFFF_FFFF & 32'h00, 32'hFFFF_FFFF);
      rd_chk("oe_mask", 32'h00, 32'h0000_0FFF, 1'b0);
      chk("oe_pin", 32'(gpio_oe), 32'hFFF);
      apb_wr(32'h2C, 32'h1, e);
      chk("undec_wr_err", {31'b0, e}, 1);

      // rising edge on pin 3
      wr(32'h1C, 32'h8);
      wr(32'h20, 32'h8);
      wr(32'h18, 32'h8);
      @(posedge clk); #1 pad[3] = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 chk("rise_irq_early", {31'b0, irq}, 0);
      @(posedge clk); #1 chk("rise_irq", {31'b0, irq}, 1);
      rd_chk("rise_in", 32'h08, 32'h008, 1'b0);
      rd_chk("rise_stat", 32'h28, 32'h008, 1'b0);
      wr(32'h28, 32'h8);
      rd_chk("rise_w1c", 32'h28, 0, 1'b0);
      chk("rise_w1c_irq", {31'b0, irq}, 0);

      // level-low on pin 5
      wr(32'h18, 32'h0);
      wr(32'h1C, 32'h0);
      wr(32'h20, 32'h0);
      wr(32'h28, 32'hFFF);
      wr(32'h18, 32'h20);
      rd_chk("lvl_stat", 32'h28, 32'h20, 1'b0);
      wr(32'h28, 32'h20);
      rd_chk("lvl_reassert", 32'h28, 32'h20, 1'b0);
      chk("lvl_irq", {31'b0, irq}, 1);
      pad[5] = 1'b1;
      repeat (4) @(posedge clk);
      wr(32'h28, 32'h20);
      rd_chk("lvl_clear", 32'h28, 0, 1'b0);
      chk("lvl_irq_clr", {31'b0, irq}, 0);

      // both edges on pin 0
      wr(32'h18, 32'h0);
      wr(32'h1C, 32'h1);
      wr(32'h24, 32'h1);
      wr(32'h28, 32'hFFF);
      wr(32'h18, 32'h1);
      pad[0] = 1'b1;
      repeat (4) @(posedge clk);
      rd_chk("both_rise", 32'h28, 32'h1, 1'b0);
      wr(32'h28, 32'h1);
      rd_chk("both_clr1", 32'h28, 0, 1'b0);
      pad[0] = 1'b0;
      repeat (4) @(posedge clk);
      rd_chk("both_fall", 32'h28, 32'h1, 1'b0);
      wr(32'h28, 32'h1);
      rd_chk("both_clr2", 32'h28, 0, 1'b0);
      @(posedge clk); #1 pad[0] = 1'b1;
      wr(32'h28, 32'h1);
      rd_chk("set_wins_w1c", 32'h28, 32'h1, 1'b0);
      chk("set_wins_irq", {31'b0, irq}, 1);
      wr(32'h18, 32'h0);
      chk("en_mask_irq", {31'b0, irq}, 0);
      rd_chk("en_mask_keeps", 32'h28, 32'h1, 1'b0);
      wr(32'h28, 32'hFFF);

      // randomized register traffic against the reference model
      m_oe = 32'hFFF; m_out = 32'hFF0; m_type = 32'h1; m_pol = 32'h0; m_both = 32'h1;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            pad = N'($urandom);
            repeat (3) @(posedge clk);
         end
         a = addrs[$urandom_range(0, 13)];
         if ($urandom_range(0, 1) == 1 && a != 32'h18) begin
            d = $urandom;
            apb_wr(a, d, e);
            mr = model_read(a);
            chk("rnd_wr_err", {31'b0, e}, {31'b0, mr[32]});
            model_write(a, d);
         end else begin
            apb_rd(a, d, e);
            mr = model_read(a);
            chk("rnd_rd", d, mr[31:0]);
            chk("rnd_rd_err", {31'b0, e}, {31'b0, mr[32]});
         end
         chk("rnd_o", 32'(gpio_o), m_out);
         chk("rnd_oe", 32'(gpio_oe), m_oe);
      end
      chk("rnd_irq", {31'b0, irq}, 0);

      // asynchronous reset mid-operation
      wr(32'h04, 32'hABC);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("arst_o", 32'(gpio_o), 0);
      chk("arst_oe", 32'(gpio_oe), 0);
      chk("arst_irq", {31'b0, irq}, 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised APB GPIO controller: NUM_PINS bidirectional pins with direction and output registers, atomic set/clear/toggle of outputs, metastability-safe input sampling, and per-pin edge/level interrupts merged into one `irq` line. Sits on the APB peripheral bus beside the UART/timer blocks. Pad buffers are instantiated at chip top, so this block exposes split `gpio_i`/`gpio_o`/`gpio_oe` vectors.

## Interface
- NUM_PINS, 32: implemented pins, 1..32; register bits at or above NUM_PINS read 0 and ignore writes.
- SYNC_STAGES, 2: input synchroniser depth, 2..3.
- apb_pclk  in  1  clock.
- apb_prstn  in  1  reset, asynchronous, active-low; the reset is apb_prstn and the clock is apb_pclk.
- apb_psel, apb_penable, apb_pwrite  in  1  APB control.
- apb_paddr  in  32  byte address; only [7:0] is decoded.
- apb_pwdata  in  32  write data.
- apb_prdata  out  32  read data.
- apb_pslverr  out  1  error on an undecoded offset.
- gpio_i  in  NUM_PINS  pad input, asynchronous.
- gpio_o  out  NUM_PINS  pad output value.
- gpio_oe  out  NUM_PINS  pad output enable, 1 = drive.
- irq  out  1  level interrupt, active-high.

## Operation
- Access strobe `acc` = psel & penable. Zero wait states.
- Register map (offset: name, access):
  - 0x00 OE, rw.
  - 0x04 OUT, rw.
  - 0x08 IN, ro: synchronised or debounced pin value.
  - 0x0C OUT_SET, wo: 1 sets the OUT bit.
  - 0x10 OUT_CLR, wo: 1 clears the OUT bit.
  - 0x14 OUT_TGL, wo: 1 inverts the OUT bit.
  - 0x18 INT_EN, rw.
  - 0x1C INT_TYPE, rw: 1 = edge, 0 = level.
  - 0x20 INT_POL, rw: 1 = rising/high, 0 = falling/low.
  - 0x24 INT_BOTH, rw: 1 = both edges; INT_POL is ignored; applies only when INT_TYPE = edge.
  - 0x28 INT_STAT, r/w1c.
  - 0x2C DB_EN, rw, macro only.
  - 0x30 DB_DIV, rw, macro only, 16 bit.
- Write-only offsets read 0.
- Undecoded offset: pslverr = 1 during acc; write ignored; prdata = 0.
- gpio_o = OUT and gpio_oe = OE, driven directly from flops.
- `s` is the synchroniser output and `p` is its one-cycle-delayed copy.
  - Rise = s & ~p; fall = ~s & p.
  - Event, edge type: rise/fall chosen by POL, or rise|fall when BOTH = 1.
  - Event, level type: s == POL.
- Status set: STAT[i] is set when event[i] & INT_EN[i]. Disabled pins never latch.
- Status clear: a W1C write clears the bit. Set wins over W1C in the same cycle, so a level source that is still active re-asserts immediately.
- irq = |(INT_STAT & INT_EN), built from flops only, so it is glitch-free.
- Clearing INT_EN[i] masks irq but does not clear STAT[i].

## Timing
- Reset: every register, synchroniser flop, `p`, gpio_o, gpio_oe and irq = 0. apb_prdata = 0, pslverr = 0.
- Write: takes effect at the apb_pclk edge that ends the access phase. The new gpio_o/gpio_oe are visible in the next cycle.
- Read: prdata is combinational during acc and 0 outside acc or on writes.
- Pad change sampled at edge k:
  - IN reflects it after edge k+SYNC_STAGES-1.
  - STAT bit and irq rise after edge k+SYNC_STAGES.
- Pulses shorter than one clock may be lost; this is not required to be detected.
- Pin held high through reset: `s` rises after reset and produces a rise event. It latches only if INT_EN is already set, so the boot default is safe.
- Reset mid-operation: asynchronous clear; all outputs return to 0 immediately.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - A 16-bit prescaler counts to DB_DIV and emits a tick. DB_DIV = 0 ticks every cycle.
  - For each pin with DB_EN = 1, the pin is sampled on each tick. The debounced value updates only when two consecutive tick samples agree.
  - Debounced value drives IN and event detection.
  - DB_EN = 0 bypasses debounce per pin.
- Not defined: offsets 0x2C/0x30 are undecoded (pslverr = 1). IN and events use `s` directly. No prescaler logic exists.

## Structure
- Package gpio_ctrl_pkg holds:
  - Register offset localparams (OFS_OE .. OFS_DB_DIV).
  - Width constant for DB_DIV (16).
  - An enum for interrupt type (EDGE/LEVEL).
- One sub-module, gpio_ctrl_pin: per-pin synchroniser, optional debounce and edge/level event generation, instantiated NUM_PINS times via generate. Register file and APB decode stay in the top.

## Test plan
- Reset state, NUM_PINS=12: read OE, OUT, INT_STAT, and offset 0x30 with the macro off -> 0, 0, 0, and 0 with pslverr=1. gpio_oe=0 and irq=0.
- Output ops:
  - Write OUT=0x0F0, then OUT_SET=0x00F -> OUT reads 0x0FF.
  - Then OUT_CLR=0x0F0 -> 0x00F.
  - Then OUT_TGL=0xFFF -> 0xFF0.
  - Write 0xFFFF_FFFF to OE -> reads 0x0000_0FFF.
- Rising edge on pin 3 with INT_EN=0x8, TYPE=0x8, POL=0x8 and SYNC_STAGES=2: pad 0->1 -> STAT=0x8 and irq=1 two cycles after sampling. W1C 0x8 -> STAT=0 and irq=0.
- Level low on pin 5 (TYPE=0, POL=0, EN=0x20), pad held 0: W1C 0x20 -> STAT stays 0x20. Pad 1, then W1C -> STAT=0.
- Both edges on pin 0 (BOTH=1): pad 0->1->0 with W1C in between -> two separate STAT sets. A W1C landing in the same cycle as a new event leaves STAT=1.
- With GPIO_DEBOUNCE_EN, DB_DIV=3, DB_EN=1: a 2-cycle glitch leaves IN unchanged. A level stable for 8 cycles -> IN updates.
